// File: rtl/rgb_pixel_port.sv
// Per-channel pixel load/store responder in front of a 24-bit synchronous pixel RAM.
// Loads return one colour byte; stores do a read-modify-write of a single channel.
module rgb_pixel_port #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int PIX_DEPTH = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              MemWrite,
    input  logic [1:0]        RGB,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP,
        WRITE,
        ERR
    } state_t;

    localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W+1)'(PIX_DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [1:0]        rgb_reg;
    logic              write_reg;
    logic [7:0]        wbyte_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [23:0]       merge_reg;

    logic              accept;
    logic              in_range;
    logic [23:0]       merged;
    logic [7:0]        lane_byte [3];
    logic [7:0]        sel_byte;
    logic              unused_wdata;

    assign accept       = req_valid && (RGB != 2'b00);
    assign in_range     = {1'b0, addr} < PIX_LIM;
    assign unused_wdata = ^wdata[DATA_W-1:8];

    // Lane gi holds byte [gi*8 +: 8]; channel code is 3-gi (R=01 at the top lane, B=11 at the bottom).
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit            = (rgb_reg == 2'(3 - gi));
            assign merged[gi*8 +: 8]   = lane_hit ? wbyte_reg : mem_rdata[gi*8 +: 8];
            assign lane_byte[gi]       = lane_hit ? mem_rdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < 3; i++) begin
            sel_byte = sel_byte | lane_byte[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_next = in_range ? ISSUE : ERR;
                end
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = write_reg ? WRITE : RESP;
            RESP: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            WRITE: begin
                done       = 1'b1;
                // Gated by reset so a reset landing on the write cycle leaves the RAM untouched.
                mem_we     = !rst;
                state_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_reg <= '0;
            rgb_reg      <= 2'b00;
            write_reg    <= 1'b0;
            wbyte_reg    <= 8'h00;
            rdata_reg    <= '0;
            merge_reg    <= 24'h000000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rgb_reg   <= RGB;
                        write_reg <= MemWrite;
                        wbyte_reg <= wdata[7:0];
                        // Out-of-range requests never touch the RAM address bus.
                        if (in_range) begin
                            mem_addr_reg <= addr;
                        end
                    end
                end
                CAPTURE: begin
                    if (write_reg) begin
                        merge_reg <= merged;
                    end else begin
                        rdata_reg <= DATA_W'(sel_byte);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = merge_reg;

endmodule
